// File: rtl/quad_input_frontend.sv
// Paddle encoder front end: 2-FF sync, per-pin debounce and quadrature decode into step/error pulses.
// Define POSITION_COUNT_EN to build the saturating per-channel position accumulators.
module quad_input_frontend #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 255,
    parameter int DECODE_MODE     = 4,
    parameter int POS_WIDTH       = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           enc_a,
    input  logic [CHANNELS-1:0]           enc_b,
    input  logic [CHANNELS-1:0]           clear_pos,
    output logic [CHANNELS-1:0]           step_up,
    output logic [CHANNELS-1:0]           step_down,
    output logic [CHANNELS-1:0]           error,
    output logic [CHANNELS*POS_WIDTH-1:0] position
);
    localparam int PINS    = 2 * CHANNELS;
    localparam int CNT_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ARM_LEN = DEBOUNCE_CYCLES + 3;
    localparam int ARM_W   = $clog2(ARM_LEN + 1);
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(ARM_LEN);

    // Pin p < CHANNELS is A of channel p; pin CHANNELS+c is B of channel c.
    logic [PINS-1:0]     raw;
    logic [PINS-1:0]     sync1_q, sync2_q;
    logic [PINS-1:0]     stable_q, stable_d;
    logic [PINS-1:0]     prev_q;
    logic [CNT_W-1:0]    cnt_q [PINS];
    logic [CNT_W-1:0]    cnt_d [PINS];
    logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
    logic                arm_done_q;
    logic                arming;
    logic [CHANNELS-1:0] up_q, up_d, dn_q, dn_d, err_q, err_d;

    assign raw       = {enc_b, enc_a};
    assign arming    = ~arm_done_q;
    assign arm_cnt_d = (arm_cnt_q == ARM_MAX) ? arm_cnt_q : arm_cnt_q + ARM_W'(1);

    always_comb begin
        stable_d = stable_q;
        for (int p = 0; p < PINS; p++) begin
            cnt_d[p] = '0;
            if (arming) begin
                stable_d[p] = sync2_q[p];
            end else if (sync2_q[p] != stable_q[p]) begin
                if (cnt_q[p] == DB_MAX) stable_d[p] = sync2_q[p];
                else                    cnt_d[p]    = cnt_q[p] + CNT_W'(1);
            end
        end
    end

    // Transition table on {prev A, prev B, cur A, cur B}; the up cycle is 00->01->11->10->00.
    always_comb begin
        up_d  = '0;
        dn_d  = '0;
        err_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case ({prev_q[c], prev_q[CHANNELS+c], stable_q[c], stable_q[CHANNELS+c]})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up_d[c]  = 1'b1;
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dn_d[c]  = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: err_d[c] = 1'b1;
                default: ;
            endcase
            if (DECODE_MODE == 1 && {stable_q[c], stable_q[CHANNELS+c]} != 2'b00) begin
                up_d[c] = 1'b0;
                dn_d[c] = 1'b0;
            end
            if (arming) begin
                up_d[c]  = 1'b0;
                dn_d[c]  = 1'b0;
                err_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            arm_cnt_q  <= '0;
            arm_done_q <= 1'b0;
            up_q       <= '0;
            dn_q       <= '0;
            err_q      <= '0;
            for (int p = 0; p < PINS; p++) cnt_q[p] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            prev_q     <= stable_q;
            arm_cnt_q  <= arm_cnt_d;
            arm_done_q <= arm_done_q | (arm_cnt_q == ARM_MAX);
            up_q       <= up_d;
            dn_q       <= dn_d;
            err_q      <= err_d;
            for (int p = 0; p < PINS; p++) cnt_q[p] <= cnt_d[p];
        end
    end

    assign step_up   = up_q;
    assign step_down = dn_q;
    assign error     = err_q;

`ifdef POSITION_COUNT_EN
    localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};

    logic signed [POS_WIDTH-1:0] pos_q [CHANNELS];

    function automatic logic signed [POS_WIDTH-1:0] sat_step(
        input logic signed [POS_WIDTH-1:0] v,
        input logic                        up,
        input logic                        dn
    );
        sat_step = v;
        if (up && v != POS_MAX) sat_step = v + POS_WIDTH'(1);
        if (dn && v != POS_MIN) sat_step = v - POS_WIDTH'(1);
    endfunction

    // The accumulator moves on the same edge that registers the step pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) pos_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (arming || clear_pos[c]) pos_q[c] <= '0;
                else                        pos_q[c] <= sat_step(pos_q[c], up_d[c], dn_d[c]);
            end
        end
    end

    always_comb begin
        position = '0;
        for (int c = 0; c < CHANNELS; c++) position[c*POS_WIDTH +: POS_WIDTH] = pos_q[c];
    end
`else
    logic unused_clear;
    assign unused_clear = ^clear_pos;
    assign position     = '0;
`endif
endmodule

// File: tb/tb_quad_input_frontend.sv
// Bench for quad_input_frontend: three configurations driven from shared pins, checked each cycle
// against a window-based behavioural model, plus literal pulse-count and position expectations.
module tb_quad_input_frontend;
    localparam int CH = 2;
    localparam int PW = 4;
    localparam int NI = 3;
    localparam int PMAX = (1 << (PW - 1)) - 1;
    localparam int PMIN = -(1 << (PW - 1));

    logic clk = 1'b0;
    logic reset_n;
    logic [CH-1:0] enc_a, enc_b, clear_pos;
    logic [CH-1:0] up [NI];
    logic [CH-1:0] dn [NI];
    logic [CH-1:0] er [NI];
    logic [CH*PW-1:0] pos [NI];

    always #5 clk = ~clk;

    quad_input_frontend #(.CHANNELS(CH), .DEBOUNCE_CYCLES(4), .DECODE_MODE(4), .POS_WIDTH(PW)) u_d4m4 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear_pos(clear_pos),
        .step_up(up[0]), .step_down(dn[0]), .error(er[0]), .position(pos[0]));
    quad_input_frontend #(.CHANNELS(CH), .DEBOUNCE_CYCLES(0), .DECODE_MODE(4), .POS_WIDTH(PW)) u_d0m4 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear_pos(clear_pos),
        .step_up(up[1]), .step_down(dn[1]), .error(er[1]), .position(pos[1]));
    quad_input_frontend #(.CHANNELS(CH), .DEBOUNCE_CYCLES(4), .DECODE_MODE(1), .POS_WIDTH(PW)) u_d4m1 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear_pos(clear_pos),
        .step_up(up[2]), .step_down(dn[2]), .error(er[2]), .position(pos[2]));

    int n_cmp, n_bad, cyc, ecount;
    int dcyc [NI];
    int dmode [NI];
    logic [9:0] hist [2*CH];
    logic [2*CH-1:0] st [NI];
    logic [1:0] pv [NI][CH];
    int mpos [NI][CH];
    int cnt_up [NI][CH];
    int cnt_dn [NI][CH];
    int cnt_er [NI][CH];
    int b_up [NI][CH];
    int b_dn [NI][CH];
    int b_er [NI][CH];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int gidx(input logic [1:0] ab);
        if (ab == 2'b00) return 0;
        if (ab == 2'b01) return 1;
        if (ab == 2'b11) return 2;
        return 3;
    endfunction

    // One clock: sample pins at the edge, advance the model, compare all DUT outputs, return at negedge.
    task automatic tick();
        logic [2*CH-1:0] smp;
        logic [CH-1:0] clr, eu, ed, ee;
        logic [CH*PW-1:0] ep;
        logic [1:0] cur;
        logic rst_now, arming, flip;
        int d;
        @(posedge clk);
        smp = {enc_b, enc_a};
        clr = clear_pos;
        rst_now = reset_n;
        #1;
        cyc++;
        if (!rst_now) ecount = 0;
        else ecount++;
        for (int i = 0; i < NI; i++) begin
            eu = '0; ed = '0; ee = '0; ep = '0;
            arming = (ecount <= dcyc[i] + 4);
            if (!rst_now) begin
                st[i] = '0;
                for (int c = 0; c < CH; c++) begin
                    pv[i][c] = 2'b00;
                    mpos[i][c] = 0;
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    cur = {st[i][c], st[i][CH+c]};
                    d = (gidx(cur) - gidx(pv[i][c])) & 3;
                    if (!arming) begin
                        eu[c] = (d == 1) && (dmode[i] == 4 || cur == 2'b00);
                        ed[c] = (d == 3) && (dmode[i] == 4 || cur == 2'b00);
                        ee[c] = (d == 2);
                    end
                    if (arming || clr[c]) mpos[i][c] = 0;
                    else if (eu[c] && mpos[i][c] < PMAX) mpos[i][c]++;
                    else if (ed[c] && mpos[i][c] > PMIN) mpos[i][c]--;
                    pv[i][c] = cur;
                end
                for (int p = 0; p < 2*CH; p++) begin
                    if (arming) begin
                        st[i][p] = hist[p][1];
                    end else begin
                        flip = 1'b1;
                        for (int k = 1; k <= 1 + dcyc[i]; k++)
                            if (hist[p][k] == st[i][p]) flip = 1'b0;
                        if (flip) st[i][p] = ~st[i][p];
                    end
                end
            end
`ifdef POSITION_COUNT_EN
            for (int c = 0; c < CH; c++) ep[c*PW +: PW] = PW'(mpos[i][c]);
`endif
            chk($sformatf("step_up[u%0d]", i), int'(up[i]), int'(eu));
            chk($sformatf("step_down[u%0d]", i), int'(dn[i]), int'(ed));
            chk($sformatf("error[u%0d]", i), int'(er[i]), int'(ee));
            chk($sformatf("position[u%0d]", i), int'(pos[i]), int'(ep));
            for (int c = 0; c < CH; c++) begin
                cnt_up[i][c] += int'(up[i][c]);
                cnt_dn[i][c] += int'(dn[i][c]);
                cnt_er[i][c] += int'(er[i][c]);
            end
        end
        for (int p = 0; p < 2*CH; p++) begin
            if (!rst_now) hist[p] = '0;
            else hist[p] = {hist[p][8:0], smp[p]};
        end
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic snap();
        b_up = cnt_up;
        b_dn = cnt_dn;
        b_er = cnt_er;
    endtask

    task automatic set_ab(input int c, input logic [1:0] ab);
        enc_a[c] = ab[1];
        enc_b[c] = ab[0];
    endtask

    task automatic walk(input int c, input logic [1:0] ab, input int n);
        set_ab(c, ab);
        cycles(n);
    endtask

    initial begin
        int c0, lat;
        logic seen;
        logic [1:0] upseq [4];
        n_cmp = 0; n_bad = 0; cyc = 0; ecount = 0;
        dcyc[0] = 4; dcyc[1] = 0; dcyc[2] = 4;
        dmode[0] = 4; dmode[1] = 4; dmode[2] = 1;
        upseq[0] = 2'b01; upseq[1] = 2'b11; upseq[2] = 2'b10; upseq[3] = 2'b00;
        for (int p = 0; p < 2*CH; p++) hist[p] = '0;
        for (int i = 0; i < NI; i++) begin
            st[i] = '0;
            for (int c = 0; c < CH; c++) begin
                pv[i][c] = 2'b00; mpos[i][c] = 0;
                cnt_up[i][c] = 0; cnt_dn[i][c] = 0; cnt_er[i][c] = 0;
            end
        end
        reset_n = 1'b0; enc_a = 2'b11; enc_b = 2'b11; clear_pos = '0;
        cycles(5);
        chk("reset_up", int'(up[0]), 0);
        chk("reset_pos", int'(pos[0]), 0);

        // Pins held at 11 across reset release: arming must swallow the change.
        reset_n = 1'b1;
        snap();
        cycles(20);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < CH; c++)
                chk($sformatf("idle11_events[u%0d ch%0d]", i, c),
                    cnt_up[i][c] + cnt_dn[i][c] + cnt_er[i][c] - b_up[i][c] - b_dn[i][c] - b_er[i][c], 0);
        chk("idle11_pos", int'(pos[0]), 0);

        snap();
        enc_a = 2'b00; enc_b = 2'b00;
        cycles(20);
        chk("11to00_error_u4", cnt_er[0][0] - b_er[0][0], 1);

        // Full up cycle on ch0 with latency measurement on the first step.
        snap();
        c0 = cyc;
        set_ab(0, 2'b01);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (lat < 0 && up[0][0]) lat = cyc - c0;
        end
        walk(0, 2'b11, 10); walk(0, 2'b10, 10); walk(0, 2'b00, 10);
        chk("up_latency", lat, 8);
        chk("up_count_u4", cnt_up[0][0] - b_up[0][0], 4);
        chk("up_count_u0", cnt_up[1][0] - b_up[1][0], 4);
        chk("up_count_mode1", cnt_up[2][0] - b_up[2][0], 1);
        chk("mode1_ch1_idle", cnt_up[2][1] + cnt_dn[2][1] + cnt_er[2][1] - b_up[2][1] - b_dn[2][1] - b_er[2][1], 0);
`ifdef POSITION_COUNT_EN
        chk("up_pos_u4", int'(pos[0][3:0]), 4);
`else
        chk("up_pos_u4_off", int'(pos[0]), 0);
`endif

        snap();
        walk(0, 2'b10, 10); walk(0, 2'b11, 10); walk(0, 2'b01, 10); walk(0, 2'b00, 10);
        chk("down_count_u4", cnt_dn[0][0] - b_dn[0][0], 4);
        chk("down_count_mode1", cnt_dn[2][0] - b_dn[2][0], 1);
        chk("down_pos_u4", int'(pos[0][3:0]), 0);

        // Bounce on A shorter than the window, then a clean 01->11 step.
        walk(0, 2'b01, 15);
        snap();
        for (int k = 0; k < 10; k++) begin
            enc_a[0] = ~enc_a[0];
            cycles(2);
        end
        chk("bounce_quiet", cnt_up[0][0] + cnt_dn[0][0] + cnt_er[0][0] - b_up[0][0] - b_dn[0][0] - b_er[0][0], 0);
        enc_a[0] = 1'b1;
        cycles(15);
        chk("bounce_one_up", cnt_up[0][0] - b_up[0][0], 1);
        chk("bounce_no_down", cnt_dn[0][0] - b_dn[0][0], 0);
        walk(0, 2'b10, 10); walk(0, 2'b00, 10);

        // Double-bit jump on ch1 with the debounce bypassed.
        snap();
        walk(1, 2'b11, 10);
        chk("d0_error_ch1", cnt_er[1][1] - b_er[1][1], 1);
        chk("d0_nostep_ch1", cnt_up[1][1] + cnt_dn[1][1] - b_up[1][1] - b_dn[1][1], 0);
        chk("d0_pos_ch1", int'(pos[1][7:4]), 0);
        walk(1, 2'b00, 10);

        // Ten up steps saturate the 4-bit accumulator at +7.
        snap();
        for (int k = 0; k < 10; k++) walk(0, upseq[k % 4], 10);
        chk("sat_up_count", cnt_up[0][0] - b_up[0][0], 10);
`ifdef POSITION_COUNT_EN
        chk("sat_pos", int'(pos[0][3:0]), PMAX);
`else
        chk("sat_pos_off", int'(pos[0]), 0);
`endif

        // Clear coinciding with a step edge on the d4 instance: clear wins, pulse still emitted.
        set_ab(0, 2'b10);
        cycles(7);
        clear_pos[0] = 1'b1;
        tick();
        clear_pos[0] = 1'b0;
        chk("clear_step_pulse", int'(up[0][0]), 1);
        chk("clear_step_pos", int'(pos[0][3:0]), 0);
        cycles(10);

        // Reset asserted while a step pulse is high.
        set_ab(0, 2'b00);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (up[0][0]) seen = 1'b1;
        end
        chk("midrst_pulse_seen", int'(seen), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_up", int'(up[0]), 0);
        chk("midrst_pos", int'(pos[0]), 0);
        chk("midrst_err_u0", int'(er[1]), 0);
        cycles(3);
        reset_n = 1'b1;
        cycles(20);

        // Random pin activity and clears.
        for (int r = 0; r < 150; r++) begin
            enc_a = CH'($urandom);
            enc_b = CH'($urandom);
            for (int h = 0; h < $urandom_range(1, 12); h++) begin
                clear_pos = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
                tick();
            end
        end
        clear_pos = '0;
        cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
